// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control path.
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;
endpackage

// File: rtl/mc_ctrl_rom.sv
// mc_ctrl_rom: combinational state -> datapath control word decode.
module mc_ctrl_rom
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multicycle MIPS-subset datapath,
// with memory-ready stalls, illegal-opcode skip and a retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state_out,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire, legal, fetch_ok;
    ctrl_t            cw;

    mc_ctrl_rom u_rom (.state(state_q), .ctrl(cw));

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        legal   = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                  (opcode == OP_BEQ) || (opcode == OP_J);
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                                (opcode == OP_RTYPE) ? S_EXEC :
                                (opcode == OP_BEQ)   ? S_BRANCH :
                                (opcode == OP_J)     ? S_JUMP : S_FETCH;
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
                retire  = mem_ready;
            end
            S_EXEC:   state_d = S_RWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP: retire = 1'b1;
            default:  state_d = S_FETCH;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // IR and PC only load in FETCH once memory delivers the instruction
    assign fetch_ok      = mem_ready || (state_q != S_FETCH);
    assign pc_write      = rst_n & cw.pc_write & fetch_ok;
    assign ir_write      = rst_n & cw.ir_write & fetch_ok;
    assign pc_write_cond = rst_n & cw.pc_write_cond;
    assign pc_en         = pc_write | (pc_write_cond & zero);
    assign iord          = rst_n & cw.iord;
    assign mem_read      = rst_n & cw.mem_read;
    assign mem_write     = rst_n & cw.mem_write;
    assign mem_to_reg    = rst_n & cw.mem_to_reg;
    assign reg_dst       = rst_n & cw.reg_dst;
    assign reg_write     = rst_n & cw.reg_write;
    assign alu_src_a     = rst_n & cw.alu_src_a;
    assign alu_src_b     = rst_n ? cw.alu_src_b : 2'b00;
    assign alu_op        = rst_n ? cw.alu_op : 2'b00;
    assign pc_source     = rst_n ? cw.pc_source : 2'b00;
    assign state_out     = rst_n ? state_q : 4'd0;
    assign illegal_op    = rst_n & (state_q == S_DECODE) & ~legal;
    assign instr_count   = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level schedule model checked every cycle,
// plus literal latency/counter checks and a 2-bit-counter instance for wrap.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic        pc_write;
        logic        pc_write_cond;
        logic        pc_en;
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        logic        mem_to_reg;
        logic        reg_dst;
        logic        reg_write;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [1:0]  alu_op;
        logic [1:0]  pc_source;
        logic [3:0]  state_out;
        logic        illegal_op;
        logic [31:0] instr_count;
    } out_t;

    logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_out;
    logic [31:0] instr_count;
    logic d2_pw, d2_pwc, d2_pe, d2_io, d2_mr, d2_mw, d2_iw, d2_m2r, d2_rd, d2_rw, d2_asa, d2_ill;
    logic [1:0] d2_asb, d2_aop, d2_ps, cnt2;
    logic [3:0] d2_st;

    out_t act, expv;
    logic exp_valid = 1'b0;
    int n_cmp = 0, n_bad = 0, ncyc = 0;
    logic [31:0] c = 0;

    multicycle_control u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state_out(state_out), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(d2_pw), .pc_write_cond(d2_pwc), .pc_en(d2_pe), .iord(d2_io),
        .mem_read(d2_mr), .mem_write(d2_mw), .ir_write(d2_iw),
        .mem_to_reg(d2_m2r), .reg_dst(d2_rd), .reg_write(d2_rw),
        .alu_src_a(d2_asa), .alu_src_b(d2_asb), .alu_op(d2_aop),
        .pc_source(d2_ps), .state_out(d2_st), .illegal_op(d2_ill),
        .instr_count(cnt2)
    );

    assign act = {pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, state_out, illegal_op, instr_count};

    always #5 clk = ~clk;

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(63));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    // Expected outputs for one cycle spent in a given instruction phase
    function automatic out_t exp_of(input logic [3:0] st, input logic r, input logic z,
                                    input logic [5:0] op, input logic [31:0] cnt);
        out_t e = '0;
        e.state_out = st;
        e.instr_count = cnt;
        case (st)
            S_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = r; e.pc_write = r; end
            S_DECODE: begin
                e.alu_src_b = 2'b11;
                e.illegal_op = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                                 op == 6'b000100 || op == 6'b000010);
            end
            S_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_MEMRD:  begin e.mem_read = 1; e.iord = 1; end
            S_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            S_MEMWR:  begin e.mem_write = 1; e.iord = 1; end
            S_EXEC:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            S_RWB:    begin e.reg_write = 1; e.reg_dst = 1; end
            S_BRANCH: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            S_JUMP:   begin e.pc_write = 1; e.pc_source = 2'b10; end
            default:  e = '0;
        endcase
        e.pc_en = e.pc_write | (e.pc_write_cond & z);
        return e;
    endfunction

    always @(negedge clk) begin
        #2;
        if (exp_valid) begin
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got %h expected %h", $time, act, expv);
            end
            n_cmp++;
            if (cnt2 !== expv.instr_count[1:0]) begin
                n_bad++;
                $display("FAIL wrap_count t=%0t: got %0d expected %0d", $time, cnt2, expv.instr_count[1:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic do_cycle(input logic [3:0] st, input logic r, input logic [5:0] op, input int zsel);
        logic z;
        @(negedge clk);
        z = (zsel == 2) ? rb() : 1'(zsel);
        rst_n = 1'b1;
        mem_ready = r;
        opcode = op;
        zero = z;
        expv = exp_of(st, r, z, op, c);
        exp_valid = 1'b1;
        ncyc++;
    endtask

    task automatic do_reset(input int n, input bit check_first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            mem_ready = 1'b1;
            opcode = rnd6();
            zero = rb();
            expv = '0;
            expv.instr_count = (i == 0) ? c : 32'd0;
            exp_valid = (i > 0) || check_first;
        end
        c = 0;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fst, input int mst, input int zsel);
        logic [3:0] ms;
        for (int i = 0; i < fst; i++) do_cycle(S_FETCH, 1'b0, rnd6(), zsel);
        do_cycle(S_FETCH, 1'b1, rnd6(), zsel);
        do_cycle(S_DECODE, rb(), op, zsel);
        if (op == 6'b100011 || op == 6'b101011) begin
            ms = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
            do_cycle(S_MEMADR, rb(), op, zsel);
            for (int i = 0; i < mst; i++) do_cycle(ms, 1'b0, op, zsel);
            do_cycle(ms, 1'b1, op, zsel);
            if (op == 6'b100011) do_cycle(S_MEMWB, rb(), op, zsel);
            c++;
        end else if (op == 6'b000000) begin
            do_cycle(S_EXEC, rb(), op, zsel);
            do_cycle(S_RWB, rb(), op, zsel);
            c++;
        end else if (op == 6'b000100) begin
            do_cycle(S_BRANCH, rb(), op, zsel);
            c++;
        end else if (op == 6'b000010) begin
            do_cycle(S_JUMP, rb(), op, zsel);
            c++;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        logic [5:0] ops [5];
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b000010;
        do_reset(3, 1'b0);
        settle();
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_count", instr_count, 32'd0);

        n0 = ncyc; run_instr(6'b100011, 0, 0, 2); settle();
        chk("lw_latency", 32'(ncyc - n0), 32'd5);
        chk("lw_count", instr_count, 32'd1);

        n0 = ncyc; run_instr(6'b000000, 0, 0, 2); settle();
        chk("rtype_latency", 32'(ncyc - n0), 32'd4);

        n0 = ncyc; run_instr(6'b000100, 0, 0, 1); settle();
        chk("beq_latency", 32'(ncyc - n0), 32'd3);
        run_instr(6'b000100, 0, 0, 0);

        n0 = ncyc; run_instr(6'b000010, 0, 0, 2); settle();
        chk("j_latency", 32'(ncyc - n0), 32'd3);

        n0 = ncyc; run_instr(6'b101011, 0, 3, 2); settle();
        chk("sw_stall_latency", 32'(ncyc - n0), 32'd7);
        chk("count_after_six", instr_count, 32'd6);

        n0 = ncyc; run_instr(6'b001000, 0, 0, 2); settle();
        chk("illegal_latency", 32'(ncyc - n0), 32'd2);
        chk("illegal_count", instr_count, 32'd6);

        do_cycle(S_FETCH, 1'b1, rnd6(), 2);
        do_cycle(S_DECODE, 1'b1, 6'b100011, 2);
        do_cycle(S_MEMADR, 1'b1, 6'b100011, 2);
        do_cycle(S_MEMRD, 1'b0, 6'b100011, 2);
        do_reset(2, 1'b1);
        settle();
        chk("abort_count", instr_count, 32'd0);

        for (int k = 0; k < 300; k++) begin
            logic [5:0] op;
            op = ($urandom_range(5) == 0) ? rnd6() : ops[$urandom_range(4)];
            run_instr(op, $urandom_range(3), $urandom_range(3), 2);
            if ($urandom_range(40) == 0) do_reset(1 + $urandom_range(2), 1'b1);
        end

        @(negedge clk);
        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
